ifetch_queue: RTL and testbench
===============================

# ifetch_queue

Parametrised instruction-fetch front end that owns the program counter, issues fetches to a synchronous instruction ROM and buffers returned words in a DEPTH-entry FIFO ahead of the IF/ID pipeline register. It adds credit-based flow control, downstream backpressure and jump redirect with flush, which the single-register PC/fetch path lacks. It sits between the instruction ROM and `if_id`.

## Interface
- ADDR_W, 32, PC and ROM address width
- INST_W, 32, instruction word width
- DEPTH, 4, FIFO entries; power of two, ≥2
- RESET_PC, 0, PC value loaded on reset

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- rom_req_o  out  1  fetch request this cycle
- rom_addr_o  out  ADDR_W  fetch address, equals PC register
- rom_inst_i  in  INST_W  ROM data, valid exactly 1 cycle after a request
- jump_en_i  in  1  redirect/flush strobe
- jump_addr_i  in  ADDR_W  redirect target; bits [1:0] forced to 0
- inst_o  out  INST_W  head-of-queue instruction
- inst_addr_o  out  ADDR_W  address of inst_o
- valid_o  out  1  inst_o/inst_addr_o valid
- ready_i  in  1  downstream accepts head
- count_o  out  $clog2(DEPTH+1)  occupied entries

## Operation
- State: PC, in-flight flag plus in-flight address, FIFO storage with read/write pointers (log2(DEPTH) bits, natural wrap) and count.
- pop = valid_o & ready_i & !jump_en_i.
- credit = (count + inflight − pop) < DEPTH.
- rom_req_o = credit & !jump_en_i & !rst; on request PC ← PC + 4 (modulo 2^ADDR_W), in-flight flag set, address latched.
- Response: cycle after a request, rom_inst_i and latched address are pushed at write pointer; the in-flight flag clears unless a new request issues.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Credit guarantees push never hits a full FIFO; a push on full is a design error (assertion in bench).
- Jump (jump_en_i=1): PC ← {jump_addr_i[ADDR_W-1:2],2'b00}; FIFO cleared (pointers and count to 0); in-flight response discarded (flag cleared, no push next cycle); no pop, no request this cycle. Fetching resumes next cycle at the target.
- Reset wins over jump and all other activity.
- Outputs: inst_o/inst_addr_o = entry at read pointer; valid_o = (count ≠ 0). When valid_o=0, inst_o/inst_addr_o are don't-care (implementation drives entry at read pointer).

## Timing
- Reset values: PC=RESET_PC, count_o=0, valid_o=0, rom_req_o=0, in-flight=0, pointers=0; inst_o/inst_addr_o=0 (storage cleared).
- Cycle 0 = first cycle with rst=0: rom_req_o=1, rom_addr_o=RESET_PC.
- Cycle 1: response pushed; request for RESET_PC+4.
- Cycle 2: valid_o=1, inst_addr_o=RESET_PC (2-cycle request-to-valid).
- Sustained throughput 1 instruction/cycle with ready_i held high, for any DEPTH ≥2.
- ready_i low: requests continue until count + inflight = DEPTH, then rom_req_o=0 until a pop.
- Jump at cycle J: first rom_req_o to target at J+1, valid_o with target at J+3 (J+2 with bypass).
- Reset mid-operation: all state returns to reset values at the following edge; a pending ROM response is ignored.

## Configuration
- IFETCH_QUEUE_BYPASS_EN defined: when count=0 and a non-discarded response arrives, valid_o=1 combinationally that cycle with inst_o=rom_inst_i, inst_addr_o=latched address; if ready_i=1 the word is consumed and not stored, else it is pushed. Request-to-valid latency is 1 cycle; credit formula is unchanged.
- Not defined: outputs are driven from storage only; latency is 2 cycles.

## Test plan
- Reset release, RESET_PC=0x100, ready_i=1, ROM returns address-as-data: valid_o first at cycle 2 with inst_addr_o=0x100, then 0x104, 0x108… one per cycle, no gaps.
- ready_i=0 from reset, DEPTH=4: rom_req_o exactly 4 cycles, then count_o=4 and rom_req_o=0; ready_i=1 for one cycle → count_o=3 and exactly one new request.
- Jump to 0x203 while 3 entries queued and a fetch in flight: next cycle count_o=0, valid_o=0, rom_addr_o=0x200; stale response not pushed; first valid_o carries inst_addr_o=0x200.
- Simultaneous jump and ready_i=1 with valid_o=1: no pop counted, queue flushed, no duplicate or lost target instruction.
- rst asserted mid-stream with count_o=2: next cycle all outputs at reset values, rom_addr_o=RESET_PC; fetch restarts cleanly.
- IFETCH_QUEUE_BYPASS_EN defined, empty queue, ready_i=1: valid_o rises 1 cycle after request and count_o stays 0 throughout streaming.

Source files
------------

// File: rtl/ifetch_queue.sv
// Instruction-fetch front end: PC, ROM request issue with credit flow control, DEPTH-entry
// FIFO ahead of IF/ID, jump redirect with flush. Optional IFETCH_QUEUE_BYPASS_EN forwards an empty-queue response.
module ifetch_queue #(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       INST_W   = 32,
    parameter int unsigned       DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       rom_req_o,
    output logic [ADDR_W-1:0]          rom_addr_o,
    input  logic [INST_W-1:0]          rom_inst_i,
    input  logic                       jump_en_i,
    input  logic [ADDR_W-1:0]          jump_addr_i,
    output logic [INST_W-1:0]          inst_o,
    output logic [ADDR_W-1:0]          inst_addr_o,
    output logic                       valid_o,
    input  logic                       ready_i,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] pc;
    logic              inflight;
    logic [ADDR_W-1:0] inflight_addr;
    logic [INST_W-1:0] mem_inst [DEPTH];
    logic [ADDR_W-1:0] mem_addr [DEPTH];
    logic [PW-1:0]     wptr;
    logic [PW-1:0]     rptr;
    logic [CW-1:0]     count;

    logic              resp_live;
    logic              pop;
    logic              fifo_pop;
    logic              push;
    logic [CW:0]       occupancy;
    logic              credit;

    // A response is only usable when the cycle is not being redirected.
    assign resp_live = inflight & ~jump_en_i;

`ifdef IFETCH_QUEUE_BYPASS_EN
    logic bypass;
    assign bypass      = resp_live & (count == '0);
    assign valid_o     = (count != '0) | bypass;
    assign inst_o      = bypass ? rom_inst_i    : mem_inst[rptr];
    assign inst_addr_o = bypass ? inflight_addr : mem_addr[rptr];
    assign pop         = valid_o & ready_i & ~jump_en_i;
    assign fifo_pop    = pop & ~bypass;
    assign push        = resp_live & ~(bypass & ready_i);
`else
    assign valid_o     = (count != '0);
    assign inst_o      = mem_inst[rptr];
    assign inst_addr_o = mem_addr[rptr];
    assign pop         = valid_o & ready_i & ~jump_en_i;
    assign fifo_pop    = pop;
    assign push        = resp_live;
`endif

    // Reserve a slot for every outstanding fetch so a push never meets a full FIFO.
    assign occupancy  = (CW+1)'(count) + (CW+1)'(inflight) - (CW+1)'(pop);
    assign credit     = occupancy < (CW+1)'(DEPTH);
    assign rom_req_o  = credit & ~jump_en_i & ~rst;
    assign rom_addr_o = pc;
    assign count_o    = count;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc            <= RESET_PC;
            inflight      <= 1'b0;
            inflight_addr <= '0;
            wptr          <= '0;
            rptr          <= '0;
            count         <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_inst[i] <= '0;
                mem_addr[i] <= '0;
            end
        end else if (jump_en_i) begin
            pc       <= jump_addr_i & ~ADDR_W'(3);
            inflight <= 1'b0;
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
        end else begin
            if (rom_req_o) begin
                pc            <= pc + ADDR_W'(4);
                inflight_addr <= pc;
            end
            inflight <= rom_req_o;
            if (push) begin
                mem_inst[wptr] <= rom_inst_i;
                mem_addr[wptr] <= inflight_addr;
                wptr           <= wptr + PW'(1);
            end
            if (fifo_pop) begin
                rptr <= rptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(fifo_pop);
        end
    end

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue (DEPTH=4, RESET_PC=0x100) with a synchronous ROM returning address^0xA5A50000.
module tb_ifetch_queue;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned INST_W = 32;
    localparam int unsigned DEPTH  = 4;
    localparam logic [31:0] RPC    = 32'h100;

    logic              clk = 1'b0;
    logic              rst;
    logic              rom_req;
    logic [ADDR_W-1:0] rom_addr;
    logic [INST_W-1:0] rom_inst = '0;
    logic              jump_en;
    logic [ADDR_W-1:0] jump_addr;
    logic [INST_W-1:0] inst;
    logic [ADDR_W-1:0] inst_addr;
    logic              valid;
    logic              ready;
    logic [2:0]        count;

    int checks = 0;
    int errors = 0;
    int nreq;
    bit prev_req = 1'b0;

    ifetch_queue #(
        .ADDR_W(ADDR_W), .INST_W(INST_W), .DEPTH(DEPTH), .RESET_PC(RPC)
    ) dut (
        .clk(clk), .rst(rst),
        .rom_req_o(rom_req), .rom_addr_o(rom_addr), .rom_inst_i(rom_inst),
        .jump_en_i(jump_en), .jump_addr_i(jump_addr),
        .inst_o(inst), .inst_addr_o(inst_addr), .valid_o(valid),
        .ready_i(ready), .count_o(count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] romf(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    always @(posedge clk) rom_inst <= romf(rom_addr);

    // A response arriving while the queue is full and nothing leaves would overflow.
    always @(negedge clk) begin
        if (!rst && prev_req && !jump_en) begin
            assert (!(count == 3'(DEPTH) && !(valid && ready))) else begin
                errors++;
                $error("FAIL push_on_full: count %0d with a response arriving", count);
            end
        end
        prev_req = rom_req;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b1; ready = 1'b1; jump_en = 1'b0; jump_addr = '0;
        repeat (2) @(posedge clk);
        #3;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_valid", 64'(valid), 64'd0);
        chk("rst_req", 64'(rom_req), 64'd0);
        chk("rst_addr", 64'(rom_addr), 64'(RPC));
        chk("rst_inst", 64'(inst), 64'd0);
        chk("rst_iaddr", 64'(inst_addr), 64'd0);

        // streaming from reset with ready high
        rst = 1'b0; #1;
        chk("c0_req", 64'(rom_req), 64'd1);
        chk("c0_addr", 64'(rom_addr), 64'h100);
        cyc(); #1;
        chk("c1_req", 64'(rom_req), 64'd1);
        chk("c1_addr", 64'(rom_addr), 64'h104);
        chk("c1_valid", 64'(valid), 64'd0);
        cyc(); #1;
        chk("c2_valid", 64'(valid), 64'd1);
        chk("c2_iaddr", 64'(inst_addr), 64'h100);
        chk("c2_inst", 64'(inst), 64'(romf(32'h100)));
        for (int k = 1; k <= 5; k++) begin
            cyc(); #1;
            chk("stream_valid", 64'(valid), 64'd1);
            chk("stream_iaddr", 64'(inst_addr), 64'(32'h100 + 32'(4 * k)));
            chk("stream_inst", 64'(inst), 64'(romf(32'h100 + 32'(4 * k))));
            chk("stream_count", 64'(count), 64'd1);
        end

        // backpressure from reset: exactly DEPTH requests
        rst = 1'b1; ready = 1'b0;
        cyc();
        rst = 1'b0; #1;
        nreq = 0;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) begin
                cyc(); #1;
            end
            nreq += int'(rom_req);
        end
        chk("bp_nreq", 64'(nreq), 64'd4);
        chk("bp_count", 64'(count), 64'd4);
        chk("bp_req", 64'(rom_req), 64'd0);
        chk("bp_iaddr", 64'(inst_addr), 64'h100);
        ready = 1'b1; #1;
        chk("bp_pop_req", 64'(rom_req), 64'd1);
        chk("bp_pop_addr", 64'(rom_addr), 64'h110);
        cyc(); ready = 1'b0; #1;
        chk("bp_count3", 64'(count), 64'd3);
        chk("bp_req_after", 64'(rom_req), 64'd0);
        chk("bp_iaddr2", 64'(inst_addr), 64'h104);
        cyc(); #1;
        chk("bp_refill", 64'(count), 64'd4);

        // jump with 3 queued and one fetch in flight
        ready = 1'b1; #1;
        chk("pre_jump_req", 64'(rom_req), 64'd1);
        cyc(); ready = 1'b0; #1;
        chk("pre_jump_count", 64'(count), 64'd3);
        jump_en = 1'b1; jump_addr = 32'h203; #1;
        chk("jump_noreq", 64'(rom_req), 64'd0);
        cyc(); jump_en = 1'b0; #1;
        chk("j1_count", 64'(count), 64'd0);
        chk("j1_valid", 64'(valid), 64'd0);
        chk("j1_addr", 64'(rom_addr), 64'h200);
        chk("j1_req", 64'(rom_req), 64'd1);
        cyc(); #1;
        chk("j2_count", 64'(count), 64'd0);
        chk("j2_valid", 64'(valid), 64'd0);
        cyc(); #1;
        chk("j3_valid", 64'(valid), 64'd1);
        chk("j3_iaddr", 64'(inst_addr), 64'h200);
        chk("j3_inst", 64'(inst), 64'(romf(32'h200)));
        chk("j3_count", 64'(count), 64'd1);

        // jump coinciding with an accepted head
        ready = 1'b1; jump_en = 1'b1; jump_addr = 32'h300; #1;
        chk("jp_noreq", 64'(rom_req), 64'd0);
        cyc(); jump_en = 1'b0; #1;
        chk("jp1_count", 64'(count), 64'd0);
        chk("jp1_valid", 64'(valid), 64'd0);
        chk("jp1_addr", 64'(rom_addr), 64'h300);
        cyc(); #1;
        chk("jp2_valid", 64'(valid), 64'd0);
        for (int k = 0; k < 3; k++) begin
            cyc(); #1;
            chk("jp_valid", 64'(valid), 64'd1);
            chk("jp_iaddr", 64'(inst_addr), 64'(32'h300 + 32'(4 * k)));
            chk("jp_inst", 64'(inst), 64'(romf(32'h300 + 32'(4 * k))));
        end
        ready = 1'b0; #1;
        cyc(); #1;
        chk("pre_rst_count", 64'(count), 64'd2);
        chk("pre_rst_iaddr", 64'(inst_addr), 64'h308);

        // reset in the middle of a stream
        rst = 1'b1; #1;
        chk("mrst_noreq", 64'(rom_req), 64'd0);
        cyc(); #1;
        chk("mrst_count", 64'(count), 64'd0);
        chk("mrst_valid", 64'(valid), 64'd0);
        chk("mrst_req", 64'(rom_req), 64'd0);
        chk("mrst_addr", 64'(rom_addr), 64'(RPC));
        chk("mrst_inst", 64'(inst), 64'd0);
        chk("mrst_iaddr", 64'(inst_addr), 64'd0);
        rst = 1'b0; ready = 1'b1; #1;
        chk("restart_req", 64'(rom_req), 64'd1);
        chk("restart_addr", 64'(rom_addr), 64'h100);
        cyc(); cyc(); #1;
        chk("restart_valid", 64'(valid), 64'd1);
        chk("restart_iaddr", 64'(inst_addr), 64'h100);
        cyc(); #1;
        chk("restart_iaddr2", 64'(inst_addr), 64'h104);
        chk("restart_inst2", 64'(inst), 64'(romf(32'h104)));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
